// File: rtl/hpu_pkg.sv
// Shared constants and types for the HPU physical register file with ready scoreboard.
// The optional parity feature is enabled with the HPU_PRF_PARITY_EN macro.
package hpu_pkg;

    localparam int PHY_SR_LEN   = 64;
    localparam int PHY_SR_WTH   = 32;
    localparam int PHY_SR_IDX_W = $clog2(PHY_SR_LEN);

    typedef logic [PHY_SR_IDX_W-1:0] phy_sr_index_t;
    typedef logic [PHY_SR_WTH-1:0]   data_t;

    typedef struct packed {
        data_t data;
        logic  rdy;
        logic  perr;
    } prf_rd_rsp_t;

endpackage

// File: rtl/hpu_prf_rd_stage.sv
// One read pipeline stage: registers the address and incoming response, then
// overrides the response with any same-cycle write to the registered address.
module hpu_prf_rd_stage
    import hpu_pkg::*;
#(
    parameter int NUM_WR = 2,
    parameter int AW     = PHY_SR_IDX_W,
    parameter int DW     = PHY_SR_WTH,
    parameter bit FIRST  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [AW-1:0]              addr_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       rdy_i,
    input  logic                       perr_i,
    input  logic [DW-1:0]              arr_data_i,
    input  logic                       arr_rdy_i,
    input  logic                       arr_perr_i,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]  waddr_i,
    input  logic [NUM_WR-1:0][DW-1:0]  wdata_i,
    output logic [AW-1:0]              addr_o,
    output logic [DW-1:0]              data_o,
    output logic                       rdy_o,
    output logic                       perr_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          rdy_q, rdy_d;
    logic          perr_q, perr_d;

    always_comb begin
        addr_d = addr_i;
        data_d = data_i;
        rdy_d  = rdy_i;
        perr_d = perr_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            data_q <= '0;
            rdy_q  <= 1'b1;
            perr_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            rdy_q  <= rdy_d;
            perr_q <= perr_d;
        end
    end

    // The first stage takes its base value from the array at the registered
    // address; later stages re-present what the previous stage produced.
    always_comb begin
        addr_o = addr_q;
        data_o = FIRST ? arr_data_i : data_q;
        rdy_o  = FIRST ? arr_rdy_i  : rdy_q;
        perr_o = FIRST ? arr_perr_i : perr_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && (waddr_i[j] == addr_q) && (addr_q != '0)) begin
                data_o = wdata_i[j];
                rdy_o  = 1'b1;
                perr_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hpu_prf_scb.sv
// Physical register file with per-entry ready scoreboard, N read / M write ports.
// Define HPU_PRF_PARITY_EN to store an even-parity bit per entry and report perr_o.
module hpu_prf_scb
    import hpu_pkg::*;
#(
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2,
    parameter int DEPTH     = PHY_SR_LEN,
    parameter int DATA_W    = PHY_SR_WTH,
    parameter int RD_LAT    = 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0]       raddr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]              rdata_o,
    output logic [NUM_RD-1:0]                          rrdy_o,
    input  logic [NUM_WR-1:0][$clog2(DEPTH)-1:0]       waddr_i,
    input  logic [NUM_WR-1:0]                          wr_en_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]              wdata_i,
    input  logic [NUM_ALLOC-1:0]                       alloc_en_i,
    input  logic [NUM_ALLOC-1:0][$clog2(DEPTH)-1:0]    alloc_addr_i,
    input  logic                                       flush_i,
    output logic                                       wr_conflict_o,
    output logic [NUM_RD-1:0]                          perr_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  rdy_q, rdy_d;
    logic              conf_q, conf_d;
`ifdef HPU_PRF_PARITY_EN
    logic [DEPTH-1:0]  par_q, par_d;
`endif

    always_comb begin
        mem_d  = mem_q;
        rdy_d  = rdy_q;
        conf_d = conf_q;
`ifdef HPU_PRF_PARITY_EN
        par_d  = par_q;
`endif
        // Ascending port order lets the highest-index writer win.
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && (waddr_i[j] != '0)) begin
                mem_d[waddr_i[j]] = wdata_i[j];
                rdy_d[waddr_i[j]] = 1'b1;
`ifdef HPU_PRF_PARITY_EN
                par_d[waddr_i[j]] = ^wdata_i[j];
`endif
            end
        end
        // Allocation overrides a same-cycle write; flush overrides both.
        for (int k = 0; k < NUM_ALLOC; k++) begin
            if (alloc_en_i[k] && (alloc_addr_i[k] != '0)) begin
                rdy_d[alloc_addr_i[k]] = 1'b0;
            end
        end
        if (flush_i) begin
            rdy_d = '1;
        end
        mem_d[0] = '0;
        rdy_d[0] = 1'b1;
`ifdef HPU_PRF_PARITY_EN
        par_d[0] = 1'b0;
`endif
        for (int j = 0; j < NUM_WR; j++) begin
            for (int l = j + 1; l < NUM_WR; l++) begin
                if (wr_en_i[j] && wr_en_i[l] && (waddr_i[j] == waddr_i[l]) && (waddr_i[j] != '0)) begin
                    conf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
            rdy_q  <= '1;
            conf_q <= 1'b0;
`ifdef HPU_PRF_PARITY_EN
            par_q  <= '0;
`endif
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
            rdy_q  <= rdy_d;
            conf_q <= conf_d;
`ifdef HPU_PRF_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    assign wr_conflict_o = conf_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     s1_addr;
        logic [DATA_W-1:0] s1_data;
        logic              s1_rdy;
        logic              s1_perr;
        logic              arr_perr;

`ifdef HPU_PRF_PARITY_EN
        assign arr_perr = (^mem_q[s1_addr]) ^ par_q[s1_addr];
`else
        assign arr_perr = 1'b0;
`endif

        hpu_prf_rd_stage #(
            .NUM_WR (NUM_WR),
            .AW     (AW),
            .DW     (DATA_W),
            .FIRST  (1'b1)
        ) u_s1 (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .addr_i     (raddr_i[i]),
            .data_i     ('0),
            .rdy_i      (1'b1),
            .perr_i     (1'b0),
            .arr_data_i (mem_q[s1_addr]),
            .arr_rdy_i  (rdy_q[s1_addr]),
            .arr_perr_i (arr_perr),
            .wr_en_i    (wr_en_i),
            .waddr_i    (waddr_i),
            .wdata_i    (wdata_i),
            .addr_o     (s1_addr),
            .data_o     (s1_data),
            .rdy_o      (s1_rdy),
            .perr_o     (s1_perr)
        );

        if (RD_LAT == 2) begin : g_s2
            logic [AW-1:0] s2_addr_unused;

            hpu_prf_rd_stage #(
                .NUM_WR (NUM_WR),
                .AW     (AW),
                .DW     (DATA_W),
                .FIRST  (1'b0)
            ) u_s2 (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .addr_i     (s1_addr),
                .data_i     (s1_data),
                .rdy_i      (s1_rdy),
                .perr_i     (s1_perr),
                .arr_data_i ('0),
                .arr_rdy_i  (1'b0),
                .arr_perr_i (1'b0),
                .wr_en_i    (wr_en_i),
                .waddr_i    (waddr_i),
                .wdata_i    (wdata_i),
                .addr_o     (s2_addr_unused),
                .data_o     (rdata_o[i]),
                .rdy_o      (rrdy_o[i]),
                .perr_o     (perr_o[i])
            );
        end else begin : g_s1_out
            assign rdata_o[i] = s1_data;
            assign rrdy_o[i]  = s1_rdy;
            assign perr_o[i]  = s1_perr;
        end
    end

endmodule

// File: tb/tb_hpu_prf_scb.sv
// Directed bench for hpu_prf_scb: one RD_LAT=1 instance driven by a vector table,
// plus an RD_LAT=2 instance on the same inputs for the two-stage bypass sequence.
module tb_hpu_prf_scb;

    localparam int NRD = 4;
    localparam int NWR = 2;
    localparam int NAL = 2;
    localparam int DEPTH = 64;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NRD-1:0][AW-1:0] raddr = '0;
    logic [NWR-1:0][AW-1:0] waddr = '0;
    logic [NWR-1:0]         wr_en = '0;
    logic [NWR-1:0][DW-1:0] wdata = '0;
    logic [NAL-1:0]         alloc_en = '0;
    logic [NAL-1:0][AW-1:0] alloc_addr = '0;
    logic                   flush = 1'b0;

    logic [NRD-1:0][DW-1:0] rdata1, rdata2;
    logic [NRD-1:0]         rrdy1, rrdy2, perr1, perr2;
    logic                   conf1, conf2;

    hpu_prf_scb #(.NUM_RD(NRD), .NUM_WR(NWR), .NUM_ALLOC(NAL), .DEPTH(DEPTH), .DATA_W(DW), .RD_LAT(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata1), .rrdy_o(rrdy1),
        .waddr_i(waddr), .wr_en_i(wr_en), .wdata_i(wdata), .alloc_en_i(alloc_en),
        .alloc_addr_i(alloc_addr), .flush_i(flush), .wr_conflict_o(conf1), .perr_o(perr1)
    );

    hpu_prf_scb #(.NUM_RD(NRD), .NUM_WR(NWR), .NUM_ALLOC(NAL), .DEPTH(DEPTH), .DATA_W(DW), .RD_LAT(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata2), .rrdy_o(rrdy2),
        .waddr_i(waddr), .wr_en_i(wr_en), .wdata_i(wdata), .alloc_en_i(alloc_en),
        .alloc_addr_i(alloc_addr), .flush_i(flush), .wr_conflict_o(conf2), .perr_o(perr2)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0;
        alloc_en = '0;
        flush = 1'b0;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a);
        for (int i = 0; i < NRD; i++) raddr[i] = a;
    endtask

    task automatic write(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[port] = 1'b1;
        waddr[port] = a;
        wdata[port] = d;
    endtask

    task automatic check_ports1(input string tag, input logic [DW-1:0] ed, input logic er);
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("%s_p%0d_data", tag, i), rdata1[i], ed);
            check($sformatf("%s_p%0d_rdy", tag, i), {31'd0, rrdy1[i]}, {31'd0, er});
        end
    endtask

    task automatic check_ports2(input string tag, input logic [DW-1:0] ed, input logic er);
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("%s_p%0d_data", tag, i), rdata2[i], ed);
            check($sformatf("%s_p%0d_rdy", tag, i), {31'd0, rrdy2[i]}, {31'd0, er});
        end
    endtask

    typedef struct {
        logic [AW-1:0] ra;
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          al;
        logic          alp;
        logic [AW-1:0] aa;
        logic          fl;
        logic [DW-1:0] ed;
        logic          er;
        logic          ec;
    } vec_t;

    function automatic vec_t mk(input int ra, input bit we0, input int wa0, input logic [DW-1:0] wd0,
                                input bit we1, input int wa1, input logic [DW-1:0] wd1,
                                input bit al, input bit alp, input int aa, input bit fl,
                                input logic [DW-1:0] ed, input bit er, input bit ec);
        vec_t v;
        v.ra = AW'(ra);   v.we0 = we0; v.wa0 = AW'(wa0); v.wd0 = wd0;
        v.we1 = we1;      v.wa1 = AW'(wa1); v.wd1 = wd1;
        v.al = al;        v.alp = alp; v.aa = AW'(aa);   v.fl = fl;
        v.ed = ed;        v.er = er;   v.ec = ec;
        return v;
    endfunction

    localparam int NV = 25;
    vec_t vecs [NV];

    initial begin
        // Each row's expected output is the read of the previous row's address.
        vecs[0]  = mk( 5, 1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0,  0, 0, 32'h0,        1, 0);
        vecs[1]  = mk( 0, 1, 0, 32'h1,        0, 0, 0,        0, 0,  0, 0, 32'hDEADBEEF, 1, 0);
        vecs[2]  = mk( 9, 1, 0, 32'h1,        0, 0, 0,        0, 0,  0, 0, 32'h0,        1, 0);
        vecs[3]  = mk(12, 0, 0, 0,            1, 9, 32'hA5A5, 0, 0,  0, 0, 32'hA5A5,     1, 0);
        vecs[4]  = mk(12, 0, 0, 0,            0, 0, 0,        1, 0, 12, 0, 32'h0,        1, 0);
        vecs[5]  = mk(12, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h0,        0, 0);
        vecs[6]  = mk(12, 1,12, 32'h77,       0, 0, 0,        0, 0,  0, 0, 32'h77,       1, 0);
        vecs[7]  = mk(12, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h77,       1, 0);
        vecs[8]  = mk(12, 1,12, 32'h88,       0, 0, 0,        1, 1, 12, 0, 32'h88,       1, 0);
        vecs[9]  = mk(12, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h88,       0, 0);
        vecs[10] = mk(12, 0, 0, 0,            0, 0, 0,        0, 0,  0, 1, 32'h88,       0, 0);
        vecs[11] = mk( 7, 1, 0, 32'h33,       1, 0, 32'h44,   0, 0,  0, 0, 32'h88,       1, 0);
        vecs[12] = mk( 0, 1, 7, 32'h11,       1, 7, 32'h22,   0, 0,  0, 0, 32'h22,       1, 0);
        vecs[13] = mk( 7, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h0,        1, 1);
        vecs[14] = mk( 9, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h22,       1, 1);
        vecs[15] = mk( 9, 0, 0, 0,            0, 0, 0,        1, 1,  9, 0, 32'hA5A5,     1, 1);
        vecs[16] = mk( 9, 0, 0, 0,            0, 0, 0,        0, 0,  0, 1, 32'hA5A5,     0, 1);
        vecs[17] = mk( 5, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'hA5A5,     1, 1);
        vecs[18] = mk( 0, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'hDEADBEEF, 1, 1);
        vecs[19] = mk(20, 0, 0, 0,            0, 0, 0,        1, 0, 20, 1, 32'h0,        1, 1);
        vecs[20] = mk(20, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h0,        1, 1);
        vecs[21] = mk(30, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h0,        1, 1);
        vecs[22] = mk( 0, 1,30, 32'hAAAA,     1,30, 32'hBBBB, 0, 0,  0, 0, 32'hBBBB,     1, 1);
        vecs[23] = mk(30, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'h0,        1, 1);
        vecs[24] = mk( 0, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 32'hBBBB,     1, 1);

        // Reset state on both instances.
        rst = 1'b1;
        idle();
        set_raddr('0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_ports1("reset_lat1", 32'h0, 1'b1);
        check_ports2("reset_lat2", 32'h0, 1'b1);
        check("reset_conf", {31'd0, conf1}, 32'd0);
        check("reset_perr", {28'd0, perr1}, 32'd0);
        tick();

        // Sweep every address; ports read staggered addresses.
        for (int k = 0; k <= DEPTH; k++) begin
            for (int i = 0; i < NRD; i++) raddr[i] = (k < DEPTH) ? AW'(k + i) : '0;
            #1;
            if (k > 0) begin
                check_ports1($sformatf("sweep%0d", k - 1), 32'h0, 1'b1);
                check($sformatf("sweep%0d_conf", k - 1), {31'd0, conf1}, 32'd0);
            end
            tick();
        end

        for (int r = 0; r < NV; r++) begin
            set_raddr(vecs[r].ra);
            wr_en    = {vecs[r].we1, vecs[r].we0};
            waddr[0] = vecs[r].wa0;
            wdata[0] = vecs[r].wd0;
            waddr[1] = vecs[r].wa1;
            wdata[1] = vecs[r].wd1;
            alloc_en = vecs[r].al ? (vecs[r].alp ? 2'b10 : 2'b01) : 2'b00;
            alloc_addr[0] = vecs[r].aa;
            alloc_addr[1] = vecs[r].aa;
            flush    = vecs[r].fl;
            #1;
            check_ports1($sformatf("row%0d", r), vecs[r].ed, vecs[r].er);
            check($sformatf("row%0d_conf", r), {31'd0, conf1}, {31'd0, vecs[r].ec});
            check($sformatf("row%0d_perr", r), {28'd0, perr1}, 32'd0);
            tick();
        end
        idle();

        // Reset in the middle of operation clears data, ready bits and the sticky flag.
        set_raddr(AW'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_raddr(AW'(12));
        #1;
        check_ports1("midrst_lat1", 32'h0, 1'b1);
        check_ports2("midrst_lat2", 32'h0, 1'b1);
        check("midrst_conf", {31'd0, conf1}, 32'd0);
        tick();
        set_raddr(AW'(7));
        #1;
        check_ports1("midrst_e12", 32'h0, 1'b1);
        tick();
        set_raddr('0);
        #1;
        check_ports1("midrst_e7", 32'h0, 1'b1);
        tick();

        // Two-stage read: writes in either stage's cycle reach the output.
        set_raddr(AW'(9));
        tick();
        set_raddr(AW'(9));
        write(0, AW'(9), 32'h1234);
        tick();
        idle();
        set_raddr('0);
        write(0, AW'(9), 32'h5678);
        #1;
        check_ports2("lat2_s2_bypass", 32'h5678, 1'b1);
        check_ports1("lat1_bypass", 32'h5678, 1'b1);
        tick();
        idle();
        #1;
        check_ports2("lat2_s1_bypass", 32'h5678, 1'b1);
        tick();
        #1;
        check_ports2("lat2_addr0", 32'h0, 1'b1);
        set_raddr(AW'(9));
        alloc_en = 2'b01;
        alloc_addr[0] = AW'(9);
        tick();
        idle();
        set_raddr('0);
        tick();
        #1;
        check_ports2("lat2_alloc", 32'h5678, 1'b0);
        tick();

`ifdef HPU_PRF_PARITY_EN
        // Corrupt one stored bit of entry 3 behind the parity bit's back.
        write(0, AW'(3), 32'h0000000F);
        tick();
        idle();
        u_dut.mem_q[3] = 32'h0000000E;
        set_raddr(AW'(3));
        tick();
        #1;
        for (int i = 0; i < NRD; i++) check($sformatf("par_err_p%0d", i), {31'd0, perr1[i]}, 32'd1);
        write(0, AW'(3), 32'h00000055);
        #1;
        for (int i = 0; i < NRD; i++) check($sformatf("par_byp_p%0d", i), {31'd0, perr1[i]}, 32'd0);
        tick();
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
